heap_sched: RTL and testbench

- Sequences and shares one pipelined min-heap event queue among N_CORES simulation cores in the PDES engine.
- Round-robin arbitrates per-core enqueue (new event) and dequeue (lowest-timestamp event) requests.
- Issues at most one heap operation per issue window and never drives heap enqueue and dequeue together.
- Returns dequeued events to the requesting core and withholds requests the heap cannot serve (full/empty).

---
 rtl/heap_sched_pkg.sv | 24 ++
 rtl/heap_sched_rr_arbiter.sv | 56 +++++
 rtl/heap_sched.sv | 125 ++++++++++++
 tb/tb_heap_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_sched_pkg.sv
// ============================================================================
//  Module      : heap_sched_pkg
//  Description : Shared PDES definitions: heap op encoding and event/core sizes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package heap_sched_pkg;

    localparam int c_EVENT_WIDTH = 32;
    localparam int c_N_CORES     = 4;
    localparam int c_CORE_BITS   = 2;

    // OP_ENQ_DEQ exists in the heap interface but the scheduler never issues it
    typedef enum logic [1:0] {
        OP_NOP     = 2'd0,
        OP_ENQ     = 2'd1,
        OP_DEQ     = 2'd2,
        OP_ENQ_DEQ = 2'd3
    } heap_op_e;

endpackage

`default_nettype wire

// File: rtl/heap_sched_rr_arbiter.sv
// ============================================================================
//  Module      : heap_sched_rr_arbiter
//  Description : Round-robin arbiter; pointer moves past the winner on advance.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module heap_sched_rr_arbiter #(
    parameter int N        = 4,
    parameter int IDX_BITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        req,
    input  logic                advance,
    output logic [N-1:0]        grant,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                grant_valid
);

    logic [IDX_BITS-1:0] r_ptr;
    logic [IDX_BITS-1:0] w_idx;
    int                  w_sum;

    // First requester at or after the pointer, wrapping around
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        w_sum       = 0;
        for (int k = 0; k < N; k++) begin
            w_sum = int'(r_ptr) + k;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            w_idx = IDX_BITS'(w_sum);
            if (!grant_valid && req[w_idx]) begin
                grant_valid  = 1'b1;
                grant_idx    = w_idx;
                grant[w_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (grant_idx == IDX_BITS'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/heap_sched.sv
// ============================================================================
//  Module      : heap_sched
//  Description : Shares one pipelined min-heap among N_CORES cores, one op per window.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module heap_sched
    import heap_sched_pkg::*;
#(
    parameter int WIDTH     = c_EVENT_WIDTH,
    parameter int N_CORES   = c_N_CORES,
    parameter int CORE_BITS = c_CORE_BITS,
    parameter int OP_GAP    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CORES-1:0]       enq_req,
    input  logic [N_CORES*WIDTH-1:0] enq_data,
    output logic [N_CORES-1:0]       enq_ack,
    input  logic [N_CORES-1:0]       deq_req,
    output logic [N_CORES-1:0]       deq_ack,
    output logic [WIDTH-1:0]         deq_data,
    output logic [CORE_BITS-1:0]     deq_core,
    output logic                     heap_enq,
    output logic                     heap_deq,
    output logic [WIDTH-1:0]         heap_inp_data,
    input  logic [WIDTH-1:0]         heap_out_data,
    input  logic                     heap_full,
    input  logic                     heap_empty,
    output logic                     busy
);

    localparam int c_GAP_BITS = 3;

    logic [N_CORES-1:0]   w_enq_elig;
    logic [N_CORES-1:0]   w_deq_elig;
    logic [N_CORES-1:0]   w_elig;
    logic [N_CORES-1:0]   w_grant;
    logic [CORE_BITS-1:0] w_grant_idx;
    logic                 w_grant_valid;
    logic                 w_grant_enq;
    logic                 w_issue;
    logic [WIDTH-1:0]     w_enq_word [N_CORES];

    logic [c_GAP_BITS-1:0] r_gap;
    heap_op_e              r_op;
    logic [CORE_BITS-1:0]  r_op_core;

    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_slice
        assign w_enq_word[gi] = enq_data[gi*WIDTH +: WIDTH];
    end

    // A core holding both requests is only eligible for its enqueue
    assign w_enq_elig = enq_req & {N_CORES{~heap_full}};
    assign w_deq_elig = deq_req & ~enq_req & {N_CORES{~heap_empty}};
    assign w_elig     = w_enq_elig | w_deq_elig;

    assign w_issue     = (r_gap == '0) && w_grant_valid;
    assign w_grant_enq = |(w_grant & w_enq_elig);
    assign busy        = (|enq_req) | (|deq_req) | (r_gap != '0);

    heap_sched_rr_arbiter #(
        .N        (N_CORES),
        .IDX_BITS (CORE_BITS)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (w_elig),
        .advance     (w_issue),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heap_enq      <= 1'b0;
            heap_deq      <= 1'b0;
            heap_inp_data <= '0;
            enq_ack       <= '0;
            deq_ack       <= '0;
            deq_data      <= '0;
            deq_core      <= '0;
            r_gap         <= '0;
            r_op          <= OP_NOP;
            r_op_core     <= '0;
        end else begin
            heap_enq <= 1'b0;
            heap_deq <= 1'b0;
            enq_ack  <= '0;
            deq_ack  <= '0;
            r_op     <= OP_NOP;

            // The root still held the minimum during the strobe cycle
            case (r_op)
                OP_ENQ: enq_ack[r_op_core] <= 1'b1;
                OP_DEQ: begin
                    deq_ack[r_op_core] <= 1'b1;
                    deq_data           <= heap_out_data;
                    deq_core           <= r_op_core;
                end
                default: ;
            endcase

            if (w_issue) begin
                r_gap     <= c_GAP_BITS'(OP_GAP - 1);
                r_op_core <= w_grant_idx;
                if (w_grant_enq) begin
                    heap_enq      <= 1'b1;
                    heap_inp_data <= w_enq_word[w_grant_idx];
                    r_op          <= OP_ENQ;
                end else begin
                    heap_deq <= 1'b1;
                    r_op     <= OP_DEQ;
                end
            end else if (r_gap != '0) begin
                r_gap <= r_gap - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_heap_sched.sv
// ============================================================================
//  Module      : tb_heap_sched
//  Description : Bench for heap_sched with a behavioural heap and scheduler model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_heap_sched;

    localparam int W        = 32;
    localparam int N        = 4;
    localparam int CB       = 2;
    localparam int GAP      = 2;
    localparam int HEAP_CAP = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    enq_req, deq_req, enq_ack, deq_ack;
    logic [N*W-1:0]  enq_data;
    logic [W-1:0]    deq_data, heap_inp_data, heap_out_data;
    logic [CB-1:0]   deq_core;
    logic            heap_enq, heap_deq, heap_full, heap_empty, busy;

    always #5 clk = ~clk;

    heap_sched #(.WIDTH(W), .N_CORES(N), .CORE_BITS(CB), .OP_GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .enq_req(enq_req), .enq_data(enq_data), .enq_ack(enq_ack),
        .deq_req(deq_req), .deq_ack(deq_ack), .deq_data(deq_data), .deq_core(deq_core),
        .heap_enq(heap_enq), .heap_deq(heap_deq), .heap_inp_data(heap_inp_data),
        .heap_out_data(heap_out_data), .heap_full(heap_full), .heap_empty(heap_empty),
        .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural min-heap (sorted queue) ----------------
    int unsigned hq[$];
    bit          full_ovr = 1'b0;
    logic        p_enq = 1'b0, p_deq = 1'b0;
    logic [W-1:0] p_data = '0;

    task automatic heap_refresh();
        heap_empty    = (hq.size() == 0);
        heap_full     = full_ovr || (hq.size() >= HEAP_CAP);
        heap_out_data = heap_empty ? '0 : hq[0];
    endtask

    always @(negedge clk) begin
        p_enq  = heap_enq;
        p_deq  = heap_deq;
        p_data = heap_inp_data;
    end

    // The heap applies an op just after the edge that ends its strobe cycle
    initial begin
        int pos;
        heap_refresh();
        forever begin
            @(posedge clk);
            #1;
            if (p_enq === 1'b1) begin
                pos = 0;
                while (pos < hq.size() && hq[pos] <= p_data) pos++;
                hq.insert(pos, p_data);
            end
            if (p_deq === 1'b1 && hq.size() > 0) void'(hq.pop_front());
            heap_refresh();
        end
    end

    // ---------------- scheduler reference model + per-cycle compare ----------------
    int   m_ptr = 0, m_edge = 0, m_next_ok = 0, m_core = 0, m_c = 0;
    bit   m_pend = 1'b0, m_pend_enq = 1'b0, m_found = 1'b0, m_gap_open = 1'b0;
    logic         e_henq = 1'b0, e_hdeq = 1'b0;
    logic [N-1:0] e_eack = '0, e_dack = '0;
    logic [W-1:0] e_ddata = '0, e_inp = '0;
    logic [CB-1:0] e_dcore = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_ptr = 0; m_edge = 0; m_next_ok = 0; m_pend = 1'b0; m_gap_open = 1'b0;
                e_henq = 1'b0; e_hdeq = 1'b0; e_eack = '0; e_dack = '0;
                e_ddata = '0; e_dcore = '0;
            end else begin
                e_eack = '0;
                e_dack = '0;
                if (m_pend) begin
                    if (m_pend_enq) begin
                        e_eack[m_core] = 1'b1;
                    end else begin
                        e_dack[m_core] = 1'b1;
                        e_ddata        = heap_out_data;
                        e_dcore        = CB'(m_core);
                    end
                end
                m_pend  = 1'b0;
                e_henq  = 1'b0;
                e_hdeq  = 1'b0;
                m_found = 1'b0;
                if (m_edge >= m_next_ok) begin
                    for (int k = 0; k < N; k++) begin
                        m_c = (m_ptr + k) % N;
                        if (!m_found) begin
                            if (enq_req[m_c] && !heap_full) begin
                                m_found = 1'b1; e_henq = 1'b1; m_pend_enq = 1'b1;
                                e_inp = enq_data[m_c*W +: W];
                            end else if (deq_req[m_c] && !enq_req[m_c] && !heap_empty) begin
                                m_found = 1'b1; e_hdeq = 1'b1; m_pend_enq = 1'b0;
                            end
                            if (m_found) begin
                                m_pend    = 1'b1;
                                m_core    = m_c;
                                m_ptr     = (m_c + 1) % N;
                                m_next_ok = m_edge + GAP;
                            end
                        end
                    end
                end
                m_gap_open = (m_edge < m_next_ok - 1);
                m_edge++;
            end
            #1;
            check("cyc_heap_enq", heap_enq, e_henq);
            check("cyc_heap_deq", heap_deq, e_hdeq);
            check("cyc_enq_ack", enq_ack, e_eack);
            check("cyc_deq_ack", deq_ack, e_dack);
            check("cyc_deq_data", deq_data, e_ddata);
            check("cyc_deq_core", deq_core, e_dcore);
            check("cyc_busy", busy, (|enq_req) | (|deq_req) | m_gap_open);
            check("cyc_enq_and_deq", heap_enq & heap_deq, 1'b0);
            if (e_henq) check("cyc_inp_data", heap_inp_data, e_inp);
        end
    end

    // ---------------- directed stimulus (cores drop requests on ack) ----------------
    int cyc = 0;
    int dq_core_log[$];
    int dq_data_log[$];
    int eack_cnt[N];

    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (enq_ack[i]) begin
                enq_req[i] = 1'b0;
                eack_cnt[i]++;
            end
            if (deq_ack[i]) begin
                deq_req[i] = 1'b0;
                dq_core_log.push_back(i);
                dq_data_log.push_back(int'(deq_data));
            end
        end
    endtask

    task automatic wait_strobe(input bit want_enq, input string name);
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            step();
            if (want_enq ? heap_enq : heap_deq) ok = 1'b1;
        end
        if (!ok) timeout_fail(name);
    endtask

    initial begin
        int iss_cyc[$];
        int iss_dat[$];
        int t2_exp[4];
        int t3_exp[5];
        int n_s;
        int first_strobe;

        t2_exp = '{7, 3, 9, 1};
        t3_exp = '{1, 3, 7, 9, 16};
        for (int i = 0; i < N; i++) eack_cnt[i] = 0;
        rst_n = 1'b0; enq_req = '0; deq_req = '0; enq_data = '0;

        repeat (3) @(negedge clk);
        check("rst_heap_enq", heap_enq, 0);
        check("rst_heap_deq", heap_deq, 0);
        check("rst_enq_ack", enq_ack, 0);
        check("rst_deq_ack", deq_ack, 0);
        check("rst_deq_data", deq_data, 0);
        check("rst_deq_core", deq_core, 0);
        check("rst_inp_data", heap_inp_data, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Single enqueue from core 0
        enq_data[0*W +: W] = 32'h10;
        enq_req[0] = 1'b1;
        wait_strobe(1'b1, "t1_issue");
        check("t1_inp_data", heap_inp_data, 32'h10);
        step();
        check("t1_enq_ack", enq_ack, 4'b0001);
        step();
        check("t1_ack_one_cycle", enq_ack, 4'b0000);

        // Fresh pointer, then all four cores enqueue at once
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        enq_data = {32'd1, 32'd9, 32'd3, 32'd7};
        enq_req  = 4'b1111;
        for (int k = 0; k < 30 && iss_dat.size() < 4; k++) begin
            step();
            if (heap_enq) begin
                iss_cyc.push_back(cyc);
                iss_dat.push_back(int'(heap_inp_data));
            end
        end
        step();
        check("t2_issue_count", iss_dat.size(), 4);
        for (int k = 0; k < iss_dat.size() && k < 4; k++) begin
            check("t2_grant_order", iss_dat[k], t2_exp[k]);
            if (k > 0) check("t2_spacing", iss_cyc[k] - iss_cyc[k-1], GAP);
        end
        for (int i = 0; i < N; i++) check("t2_enq_ack_count", eack_cnt[i], (i == 0) ? 2 : 1);

        // Core 2 drains the heap
        dq_core_log.delete();
        dq_data_log.delete();
        deq_req[2] = 1'b1;
        for (int k = 0; k < 60 && dq_data_log.size() < 5; k++) begin
            step();
            if (!deq_req[2] && dq_data_log.size() < 5) deq_req[2] = 1'b1;
        end
        check("t3_deq_count", dq_data_log.size(), 5);
        for (int k = 0; k < dq_data_log.size() && k < 5; k++) begin
            check("t3_deq_data", dq_data_log[k], t3_exp[k]);
            check("t3_deq_core", dq_core_log[k], 2);
        end

        // Dequeue stalls on empty until core 0 enqueues
        dq_core_log.delete();
        dq_data_log.delete();
        deq_req[1] = 1'b1;
        n_s = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (heap_deq) n_s++;
        end
        check("t4_no_heap_deq", n_s, 0);
        check("t4_no_deq_ack", dq_data_log.size(), 0);
        enq_data[0*W +: W] = 32'h5;
        enq_req[0] = 1'b1;
        first_strobe = 0;
        for (int k = 0; k < 30 && dq_data_log.size() < 1; k++) begin
            step();
            if (first_strobe == 0 && heap_enq) first_strobe = 1;
            if (first_strobe == 0 && heap_deq) first_strobe = 2;
        end
        check("t4_enq_first", first_strobe, 1);
        check("t4_deq_count", dq_data_log.size(), 1);
        if (dq_data_log.size() > 0) begin
            check("t4_deq_core", dq_core_log[0], 1);
            check("t4_deq_data", dq_data_log[0], 32'h5);
        end

        // Full heap: dequeue proceeds, enqueue waits
        enq_data[3*W +: W] = 32'h22;
        enq_req[3] = 1'b1;
        for (int k = 0; k < 20 && enq_req[3]; k++) step();
        check("t5_preload_acked", enq_req[3], 0);
        full_ovr = 1'b1;
        step();
        step();
        dq_core_log.delete();
        dq_data_log.delete();
        enq_data[0*W +: W] = 32'h33;
        enq_req[0] = 1'b1;
        deq_req[3] = 1'b1;
        n_s = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (heap_enq) n_s++;
        end
        check("t5_no_enq_while_full", n_s, 0);
        check("t5_enq_still_pending", enq_req[0], 1);
        check("t5_deq_count", dq_data_log.size(), 1);
        if (dq_data_log.size() > 0) begin
            check("t5_deq_core", dq_core_log[0], 3);
            check("t5_deq_data", dq_data_log[0], 32'h22);
        end
        full_ovr = 1'b0;
        wait_strobe(1'b1, "t5_enq_after_full");
        check("t5_inp_data", heap_inp_data, 32'h33);
        step();
        check("t5_enq_ack", enq_ack, 4'b0001);

        // Reset during a dequeue strobe
        deq_req[1] = 1'b1;
        wait_strobe(1'b0, "t6_deq_issue");
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_heap_deq", heap_deq, 0);
        check("t6_rst_heap_enq", heap_enq, 0);
        check("t6_rst_deq_ack", deq_ack, 0);
        check("t6_rst_enq_ack", enq_ack, 0);
        deq_req = '0;
        enq_req = '0;
        step();
        step();
        rst_n = 1'b1;
        enq_data[0*W +: W] = 32'h40;
        enq_data[2*W +: W] = 32'h41;
        enq_req = 4'b0101;
        wait_strobe(1'b1, "t6_restart_issue");
        check("t6_ptr_restart", heap_inp_data, 32'h40);
        for (int k = 0; k < 20 && enq_req != 4'b0000; k++) step();
        check("t6_both_acked", enq_req, 4'b0000);

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
